// File: rtl/r5p_wbu_pkg.sv
// r5p_wbu_pkg: shared types and the load-data extension helper for the write-back unit
package r5p_wbu_pkg;
  typedef enum logic [1:0] {LS_B = 2'd0, LS_H = 2'd1, LS_W = 2'd2} ld_siz_t;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} wbu_state_t;
  localparam int XMAX = 64;
  function automatic logic [XMAX-1:0] ld_ext(input logic [XMAX-1:0] d, input logic [6:0] w, input logic uns);
    logic [XMAX-1:0] m;
    m = (64'd1 << w) - 64'd1;
    return (d & m) | ({XMAX{~uns & d[w - 7'd1]}} & ~m);
  endfunction
endpackage

// File: rtl/r5p_ld_align.sv
// r5p_ld_align: selects the addressed byte/half lane of a load response and sign/zero extends it
module r5p_ld_align
  import r5p_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdt,
  input  logic [1:0]      i_siz,
  input  logic            i_uns,
  input  logic [1:0]      i_adr,
  output logic [XLEN-1:0] o_dat
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b = i_rdt[{i_adr, 3'b000} +: 8];
  assign w_h = i_rdt[{i_adr[1], 4'b0000} +: 16];
  assign o_dat = (i_siz == LS_B) ? XLEN'(ld_ext(XMAX'(w_b), 7'd8, i_uns)) :
                 (i_siz == LS_H) ? XLEN'(ld_ext(XMAX'(w_h), 7'd16, i_uns)) : i_rdt;
endmodule

// File: rtl/r5p_wbu.sv
// r5p_wbu: merges ALU results and one outstanding load into the GPR write port, with hazard stalls and a response watchdog
module r5p_wbu
  import r5p_wbu_pkg::*;
#(
  parameter int AW   = 5,
  parameter int XLEN = 32,
  parameter int TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_wen,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_wdt,
  input  logic            ld_req,
  input  logic [AW-1:0]   ld_rd,
  input  logic [1:0]      ld_siz,
  input  logic            ld_uns,
  input  logic [1:0]      ld_adr,
  input  logic            mem_rvl,
  input  logic [XLEN-1:0] mem_rdt,
  input  logic            id_e_rs1,
  input  logic            id_e_rs2,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  output logic            e_rd,
  output logic [AW-1:0]   a_rd,
  output logic [XLEN-1:0] d_rd,
  output logic            stall,
  output logic            busy,
  output logic            err
);
  localparam int CW = $clog2(TMO + 1);
  wbu_state_t      r_state, w_state_n;
  logic [AW-1:0]   r_rd;
  logic [1:0]      r_siz;
  logic            r_uns;
  logic [1:0]      r_adr;
  logic [CW-1:0]   r_cnt;
  logic            w_wait, w_rsp, w_tmo, w_lat, w_hz, w_stall, w_we_ex;
  logic [XLEN-1:0] w_ld;
  assign w_wait  = (r_state == WAIT);
  assign w_rsp   = w_wait & mem_rvl;
  assign w_tmo   = w_wait & ~mem_rvl & (r_cnt == CW'(TMO));
  assign w_lat   = ld_req & (~w_wait | mem_rvl);
  assign w_hz    = (r_rd != '0);
  assign w_stall = w_wait & ((mem_rvl & ex_wen) |
                             (w_hz & ((id_e_rs1 & (id_rs1 == r_rd)) | (id_e_rs2 & (id_rs2 == r_rd)))) |
                             (w_hz & ex_wen & (ex_rd == r_rd)));
  assign w_we_ex = rst & ex_wen & ~w_stall;
  r5p_ld_align #(.XLEN(XLEN)) u_align (
    .i_rdt (mem_rdt),
    .i_siz (r_siz),
    .i_uns (r_uns),
    .i_adr (r_adr),
    .o_dat (w_ld)
  );
  assign e_rd  = w_rsp | w_we_ex;
  assign a_rd  = w_rsp ? r_rd : w_we_ex ? ex_rd : '0;
  assign d_rd  = w_rsp ? w_ld : w_we_ex ? ex_wdt : '0;
  assign stall = w_stall;
  assign busy  = w_wait;
  assign err   = rst & ((~w_wait & mem_rvl) | w_tmo | (w_wait & ~mem_rvl & ld_req));
  // next state: a new load may start from IDLE or on the response cycle; a timeout abandons the load
  always_comb begin
    w_state_n = (~w_wait | mem_rvl) ? (ld_req ? WAIT : IDLE) : (w_tmo ? IDLE : WAIT);
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end
  // pending load descriptor and watchdog counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_siz <= '0;
      r_uns <= 1'b0;
      r_adr <= '0;
      r_cnt <= '0;
    end else if (w_lat) begin
      r_rd  <= ld_rd;
      r_siz <= ld_siz;
      r_uns <= ld_uns;
      r_adr <= ld_adr;
      r_cnt <= '0;
    end else if (w_tmo) begin
      r_rd  <= '0;
      r_siz <= '0;
      r_uns <= 1'b0;
      r_adr <= '0;
      r_cnt <= '0;
    end else if (w_wait & ~mem_rvl) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_r5p_wbu.sv
// tb_r5p_wbu: directed vectors with hand-computed expectations for the write-back unit
module tb_r5p_wbu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_wen = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_wdt = '0;
  logic        ld_req = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [1:0]  ld_siz = '0;
  logic        ld_uns = 1'b0;
  logic [1:0]  ld_adr = '0;
  logic        mem_rvl = 1'b0;
  logic [31:0] mem_rdt = '0;
  logic        id_e_rs1 = 1'b0;
  logic        id_e_rs2 = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        e_rd;
  logic [4:0]  a_rd;
  logic [31:0] d_rd;
  logic        stall, busy, err;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  r5p_wbu #(.AW(5), .XLEN(32), .TMO(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_wdt(ex_wdt),
    .ld_req(ld_req), .ld_rd(ld_rd), .ld_siz(ld_siz), .ld_uns(ld_uns), .ld_adr(ld_adr),
    .mem_rvl(mem_rvl), .mem_rdt(mem_rdt),
    .id_e_rs1(id_e_rs1), .id_e_rs2(id_e_rs2), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd), .stall(stall), .busy(busy), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #2;
  endtask
  task automatic req(input logic [4:0] rd, input logic [1:0] siz, input logic uns, input logic [1:0] adr);
    ld_req = 1'b1; ld_rd = rd; ld_siz = siz; ld_uns = uns; ld_adr = adr;
    tick();
    ld_req = 1'b0;
  endtask
  task automatic load(input string tag, input logic [4:0] rd, input logic [1:0] siz, input logic uns,
                      input logic [1:0] adr, input logic [31:0] rdt, input logic [31:0] exp);
    req(rd, siz, uns, adr);
    mem_rvl = 1'b1; mem_rdt = rdt;
    settle();
    chk({tag, "_e"}, 32'(e_rd), 32'd1);
    chk({tag, "_a"}, 32'(a_rd), 32'(rd));
    chk({tag, "_d"}, d_rd, exp);
    tick();
    mem_rvl = 1'b0;
  endtask
  initial begin
    ex_wen = 1'b1; ex_rd = 5'd9; mem_rvl = 1'b1;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_erd", 32'(e_rd), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    ex_wen = 1'b0; mem_rvl = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    ld_req = 1'b1; ld_rd = 5'd5; ld_siz = 2'd0; ld_uns = 1'b0; ld_adr = 2'd2;
    settle();
    chk("t1_busy0", 32'(busy), 32'd0);
    tick();
    ld_req = 1'b0; mem_rvl = 1'b1; mem_rdt = 32'h12F45678;
    settle();
    chk("t1_busy1", 32'(busy), 32'd1);
    chk("t1_erd", 32'(e_rd), 32'd1);
    chk("t1_ard", 32'(a_rd), 32'd5);
    chk("t1_drd", d_rd, 32'hFFFFFFF4);
    tick();
    mem_rvl = 1'b0;
    settle();
    chk("t1_busy2", 32'(busy), 32'd0);
    chk("t1_idle_erd", 32'(e_rd), 32'd0);
    req(5'd7, 2'd1, 1'b1, 2'd2);
    mem_rvl = 1'b1; mem_rdt = 32'h8001ABCD; ex_wen = 1'b1; ex_rd = 5'd3; ex_wdt = 32'h0000DEAD;
    settle();
    chk("t2_ard", 32'(a_rd), 32'd7);
    chk("t2_drd", d_rd, 32'h00008001);
    chk("t2_stall", 32'(stall), 32'd1);
    tick();
    mem_rvl = 1'b0;
    settle();
    chk("t2_alu_erd", 32'(e_rd), 32'd1);
    chk("t2_alu_ard", 32'(a_rd), 32'd3);
    chk("t2_alu_drd", d_rd, 32'h0000DEAD);
    chk("t2_alu_stall", 32'(stall), 32'd0);
    tick();
    ex_wen = 1'b0;
    load("lh_s", 5'd10, 2'd1, 1'b0, 2'd0, 32'h12348765, 32'hFFFF8765);
    load("lb_u", 5'd11, 2'd0, 1'b1, 2'd3, 32'h9A000000, 32'h0000009A);
    load("lb_s0", 5'd12, 2'd0, 1'b0, 2'd0, 32'hFFFFFF7F, 32'h0000007F);
    load("lw", 5'd13, 2'd2, 1'b1, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);
    req(5'd4, 2'd2, 1'b0, 2'd0);
    id_e_rs1 = 1'b1; id_rs1 = 5'd4;
    settle();
    chk("t3_stall_c1", 32'(stall), 32'd1);
    tick();
    settle();
    chk("t3_stall_c2", 32'(stall), 32'd1);
    tick();
    mem_rvl = 1'b1; mem_rdt = 32'h01020304;
    settle();
    chk("t3_stall_rsp", 32'(stall), 32'd1);
    chk("t3_drd", d_rd, 32'h01020304);
    tick();
    mem_rvl = 1'b0;
    settle();
    chk("t3_stall_after", 32'(stall), 32'd0);
    id_e_rs1 = 1'b0; id_e_rs2 = 1'b1; id_rs2 = 5'd0;
    req(5'd0, 2'd2, 1'b0, 2'd0);
    settle();
    chk("t3_rd0_busy", 32'(busy), 32'd1);
    chk("t3_rd0_stall", 32'(stall), 32'd0);
    id_rs2 = 5'd8;
    ex_wen = 1'b1; ex_rd = 5'd0; ex_wdt = 32'h55;
    settle();
    chk("t3_rd0_waw", 32'(e_rd), 32'd1);
    ex_wen = 1'b0; id_e_rs2 = 1'b0;
    mem_rvl = 1'b1; mem_rdt = 32'h77;
    settle();
    chk("t3_rd0_ard", 32'(a_rd), 32'd0);
    chk("t3_rd0_drd", d_rd, 32'h77);
    tick();
    mem_rvl = 1'b0;
    req(5'd9, 2'd2, 1'b0, 2'd0);
    ex_wen = 1'b1; ex_rd = 5'd9; ex_wdt = 32'h99;
    settle();
    chk("waw_stall", 32'(stall), 32'd1);
    chk("waw_erd", 32'(e_rd), 32'd0);
    ex_rd = 5'd14;
    settle();
    chk("waw_other_stall", 32'(stall), 32'd0);
    chk("waw_other_ard", 32'(a_rd), 32'd14);
    ex_wen = 1'b0;
    ld_req = 1'b1; ld_rd = 5'd20;
    settle();
    chk("proto_err", 32'(err), 32'd1);
    ld_req = 1'b0;
    mem_rvl = 1'b1; mem_rdt = 32'h1;
    settle();
    chk("proto_keep_rd", 32'(a_rd), 32'd9);
    tick();
    mem_rvl = 1'b0;
    req(5'd15, 2'd2, 1'b0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk($sformatf("tmo_noerr%0d", i), 32'(err), 32'd0);
      tick();
    end
    settle();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd1);
    tick();
    settle();
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_err_clr", 32'(err), 32'd0);
    mem_rvl = 1'b1;
    settle();
    chk("spur_err", 32'(err), 32'd1);
    chk("spur_erd", 32'(e_rd), 32'd0);
    tick();
    mem_rvl = 1'b0;
    req(5'd1, 2'd2, 1'b0, 2'd0);
    mem_rvl = 1'b1; mem_rdt = 32'h11111111;
    ld_req = 1'b1; ld_rd = 5'd2; ld_siz = 2'd2;
    settle();
    chk("b2b_ard1", 32'(a_rd), 32'd1);
    chk("b2b_drd1", d_rd, 32'h11111111);
    chk("b2b_err", 32'(err), 32'd0);
    tick();
    ld_req = 1'b0; mem_rdt = 32'h22222222;
    settle();
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_ard2", 32'(a_rd), 32'd2);
    chk("b2b_drd2", d_rd, 32'h22222222);
    tick();
    mem_rvl = 1'b0;
    settle();
    chk("b2b_idle", 32'(busy), 32'd0);
    req(5'd6, 2'd2, 1'b0, 2'd0);
    ex_wen = 1'b1; ex_rd = 5'd8; id_e_rs1 = 1'b1; id_rs1 = 5'd6;
    settle();
    chk("arst_pre_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_erd", 32'(e_rd), 32'd0);
    ex_wen = 1'b0; id_e_rs1 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    mem_rvl = 1'b1;
    settle();
    chk("arst_spur_err", 32'(err), 32'd1);
    chk("arst_spur_erd", 32'(e_rd), 32'd0);
    tick();
    mem_rvl = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
